// File: rtl/aes_ram_sched_if.sv
// aes_ram_sched_if: host, job, RAM and AES signals of the sequencer.
// Latency: none, signal bundle only.
// Backpressure: host_gnt stalls host_req; job_rej reports dropped job_start.
// Modports: slave = the sequencer's view, master = the surrounding logic's view.
interface aes_ram_sched_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  // host access port
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic                  host_gnt;
  logic [DATA_W-1:0]     host_rdata;
  logic                  host_rvalid;
  // job control
  logic                  job_start;
  logic [ADDR_W-1:0]     job_base;
  logic                  job_busy;
  logic                  job_done;
  logic                  job_err;
  logic                  job_rej;
  // word store port
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  // AES engine
  logic                  aes_en;
  logic [4*DATA_W-1:0]   aes_in;
  logic [4*DATA_W-1:0]   aes_out;
  logic                  aes_done;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    input  job_start, job_base,
    output job_busy, job_done, job_err, job_rej,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output aes_en, aes_in,
    input  aes_out, aes_done
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    output job_start, job_base,
    input  job_busy, job_done, job_err, job_rej,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  aes_en, aes_in,
    output aes_out, aes_done
  );
endinterface

// File: rtl/aes_ram_sched.sv
// aes_ram_sched: shares one RAM port between host accesses and AES jobs (read 4 words, launch, write 4 + status).
// Latency: host write in the grant cycle, host read data one cycle later; a job takes 13 cycles minimum to job_done.
// Backpressure: host_req is stalled (host_gnt=0) outside IDLE/WAIT; job_start while busy/pending is dropped with job_rej.
// Ports: clk, rst (synchronous, active high) plus the slave modport of aes_ram_sched_if.
// Build option: define AES_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT cycles (status 0, job_err pulse).
module aes_ram_sched #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  aes_ram_sched_if.slave  bus
);

`ifdef AES_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, CAP, LAUNCH, WAIT, WR, FIN} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic [WCNT_W-1:0]     wcnt;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     pend_base;
  logic                  pend;
  logic                  err;
  logic [3*DATA_W-1:0]   pt_lo;     // plaintext words B..B+2
  logic [4*DATA_W-1:0]   ct;        // ciphertext held for the writeback
  logic                  job_ram_en;
  logic                  job_ram_we;
  logic [ADDR_W-1:0]     job_ram_addr;
  logic [DATA_W-1:0]     job_ram_wdata;
  logic                  busy_q, done_q, err_q, rej_q, aes_en_q, rvalid_q;
  logic [4*DATA_W-1:0]   aes_in_q;
  logic                  host_gnt;

  // Word written at writeback slot idx: four ciphertext words then status.
  function automatic logic [DATA_W-1:0] wr_word(input logic [2:0] idx,
                                                input logic [4*DATA_W-1:0] blk,
                                                input logic fail);
    case (idx)
      3'd0:    return blk[0*DATA_W +: DATA_W];
      3'd1:    return blk[1*DATA_W +: DATA_W];
      3'd2:    return blk[2*DATA_W +: DATA_W];
      3'd3:    return blk[3*DATA_W +: DATA_W];
      default: return fail ? '0 : '1;
    endcase
  endfunction

  // The job side never drives the port in IDLE/WAIT, so the host can be
  // muxed in combinationally without any conflict check.
  assign host_gnt        = bus.host_req && (state == IDLE || state == WAIT);
  assign bus.host_gnt    = host_gnt;
  assign bus.ram_en      = host_gnt || job_ram_en;
  assign bus.ram_we      = host_gnt ? bus.host_we    : job_ram_we;
  assign bus.ram_addr    = host_gnt ? bus.host_addr  : job_ram_addr;
  assign bus.ram_wdata   = host_gnt ? bus.host_wdata : job_ram_wdata;
  assign bus.host_rdata  = bus.ram_rdata;
  assign bus.host_rvalid = rvalid_q;
  assign bus.job_busy    = busy_q;
  assign bus.job_done    = done_q;
  assign bus.job_err     = err_q;
  assign bus.job_rej     = rej_q;
  assign bus.aes_en      = aes_en_q;
  assign bus.aes_in      = aes_in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wcnt          <= '0;
      base          <= '0;
      pend_base     <= '0;
      pend          <= 1'b0;
      err           <= 1'b0;
      pt_lo         <= '0;
      ct            <= '0;
      job_ram_en    <= 1'b0;
      job_ram_we    <= 1'b0;
      job_ram_addr  <= '0;
      job_ram_wdata <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rej_q         <= 1'b0;
      aes_en_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      aes_in_q      <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      aes_en_q <= 1'b0;
      rvalid_q <= host_gnt && !bus.host_we;
      rej_q    <= bus.job_start && (busy_q || pend);

      case (state)
        IDLE: begin
          // A pending job always goes first; a fresh job_start colliding
          // with a host request is parked so the host takes this cycle.
          if (pend || (bus.job_start && !bus.host_req)) begin
            state        <= RD;
            base         <= pend ? pend_base : bus.job_base;
            job_ram_addr <= pend ? pend_base : bus.job_base;
            pend         <= 1'b0;
            cnt          <= '0;
            err          <= 1'b0;
            busy_q       <= 1'b1;
            job_ram_en   <= 1'b1;
            job_ram_we   <= 1'b0;
          end else if (bus.job_start) begin
            pend      <= 1'b1;
            pend_base <= bus.job_base;
          end
        end

        RD: begin
          // Read data trails the address by one cycle.
          case (cnt)
            3'd1:    pt_lo[0*DATA_W +: DATA_W] <= bus.ram_rdata;
            3'd2:    pt_lo[1*DATA_W +: DATA_W] <= bus.ram_rdata;
            3'd3:    pt_lo[2*DATA_W +: DATA_W] <= bus.ram_rdata;
            default: ;
          endcase
          if (cnt == 3'd3) begin
            state      <= CAP;
            job_ram_en <= 1'b0;
          end else begin
            cnt          <= cnt + 3'd1;
            job_ram_addr <= job_ram_addr + 1'b1;
          end
        end

        CAP: begin
          aes_in_q <= {bus.ram_rdata, pt_lo};
          aes_en_q <= 1'b1;
          state    <= LAUNCH;
        end

        LAUNCH: begin
          wcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (bus.aes_done) begin
            ct            <= bus.aes_out;
            state         <= WR;
            cnt           <= '0;
            job_ram_en    <= 1'b1;
            job_ram_we    <= 1'b1;
            job_ram_addr  <= base + ADDR_W'(4);
            job_ram_wdata <= bus.aes_out[DATA_W-1:0];
          end else if (TO_EN && wcnt == WCNT_W'(TIMEOUT - 1)) begin
            // Abort: jump straight to the status slot with a zero word.
            err           <= 1'b1;
            state         <= WR;
            cnt           <= 3'd4;
            job_ram_en    <= 1'b1;
            job_ram_we    <= 1'b1;
            job_ram_addr  <= base + ADDR_W'(8);
            job_ram_wdata <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        WR: begin
          if (cnt == 3'd4) begin
            state      <= FIN;
            job_ram_en <= 1'b0;
            job_ram_we <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= !err;
            err_q      <= TO_EN && err;
          end else begin
            cnt           <= cnt + 3'd1;
            job_ram_addr  <= job_ram_addr + 1'b1;
            job_ram_wdata <= wr_word(cnt + 3'd1, ct, err);
          end
        end

        FIN: begin
          // busy is already low here, so a new request is parked, not dropped.
          state <= IDLE;
          if (bus.job_start && !pend) begin
            pend      <= 1'b1;
            pend_base <= bus.job_base;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
